// File: rtl/dtu_rd_credit_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dtu_rd_credit_arb_pkg                                                      |
// | Shared constants and request type for the credit-gated DTU read arbiter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dtu_rd_credit_arb_pkg;

  localparam int DTU_LEN_BITS   = 28;
  localparam int DTU_CRED_BEATS = 64;

  typedef struct packed {
    logic [DTU_LEN_BITS-1:0] len;
    logic [3:0]              chan;
  } dtu_rd_req_t;

endpackage
`default_nettype wire

// File: rtl/dtu_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dtu_rr_arb                                                                 |
// | Combinational masked round-robin arbiter; the pointer is held by the user. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dtu_rr_arb #(
  parameter int N_CHAN = 4,
  parameter int PTR_W  = $clog2(N_CHAN)
) (
  input  logic [N_CHAN-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_CHAN-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx,
  output logic              grant_any
);

  logic [N_CHAN-1:0] w_mask;
  logic [N_CHAN-1:0] w_masked;
  logic [N_CHAN-1:0] w_sel;
  logic              w_found;

  for (genvar i = 0; i < N_CHAN; i++) begin : g_mask
    assign w_mask[i] = (PTR_W'(i) >= ptr);
  end

  // Requests at/after the pointer win; otherwise wrap to the lowest requester.
  assign w_masked  = req & w_mask;
  assign w_sel     = (|w_masked) ? w_masked : req;
  assign grant_any = |req;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < N_CHAN; i++) begin
      if (w_sel[i] && !w_found) begin
        w_found   = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = PTR_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dtu_rd_credit_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dtu_rd_credit_arb                                                          |
// | Credit-gated round-robin read-request arbiter with tid-routed data return. |
// | Optional per-channel statistics: define DTU_CRED_STATS_EN.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dtu_rd_credit_arb
  import dtu_rd_credit_arb_pkg::*;
#(
  parameter int N_CHAN     = 4,
  parameter int DATA_BITS  = 512,
  parameter int LEN_BITS   = DTU_LEN_BITS,
  parameter int CRED_BEATS = DTU_CRED_BEATS,
  parameter int PID_BITS   = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [N_CHAN-1:0]             s_req_valid,
  output logic [N_CHAN-1:0]             s_req_ready,
  input  logic [N_CHAN*LEN_BITS-1:0]    s_req_len,
  output logic                          m_req_valid,
  input  logic                          m_req_ready,
  output logic [LEN_BITS-1:0]           m_req_len,
  output logic [$clog2(N_CHAN)-1:0]     m_req_chan,
  input  logic [DATA_BITS-1:0]          s_axis_tdata,
  input  logic [DATA_BITS/8-1:0]        s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tvalid,
  input  logic [PID_BITS-1:0]           s_axis_tid,
  output logic                          s_axis_tready,
  output logic [N_CHAN*DATA_BITS-1:0]   m_axis_tdata,
  output logic [N_CHAN*DATA_BITS/8-1:0] m_axis_tkeep,
  output logic [N_CHAN-1:0]             m_axis_tlast,
  output logic [N_CHAN-1:0]             m_axis_tvalid,
  input  logic [N_CHAN-1:0]             m_axis_tready,
  output logic                          err_pulse
`ifdef DTU_CRED_STATS_EN
  ,
  output logic [N_CHAN*32-1:0]          stat_grants,
  output logic [N_CHAN*32-1:0]          stat_stalls
`endif
);

  localparam int c_BEAT_BYTES = DATA_BITS / 8;
  localparam int c_BEAT_SHIFT = $clog2(c_BEAT_BYTES);
  localparam int c_PTR_W      = $clog2(N_CHAN);
  localparam int c_CRED_W     = $clog2(CRED_BEATS + 1);
  localparam int c_BW         = LEN_BITS + 1;
  localparam logic [c_BW-1:0]     c_CRED_MAX_B = c_BW'(CRED_BEATS);
  localparam logic [c_CRED_W-1:0] c_CRED_MAX   = c_CRED_W'(CRED_BEATS);

  logic [N_CHAN-1:0][LEN_BITS-1:0] w_len;
  logic [N_CHAN-1:0][c_BW-1:0]     w_beats;
  logic [N_CHAN-1:0][c_CRED_W-1:0] w_cred_nxt;
  logic [N_CHAN-1:0][c_CRED_W-1:0] r_credit;
  logic [N_CHAN-1:0] w_illegal, w_short, w_elig, w_req, w_gnt_oh, w_refund, w_sat;
  logic [c_PTR_W-1:0]  w_gnt_idx, r_rr_ptr, r_m_chan, w_tid_idx;
  logic                w_gnt_any, w_gnt_legal, w_gnt_ill, w_can_grant, w_drain;
  logic                w_tid_ok, w_data_err;
  logic                r_m_valid, r_err;
  logic [LEN_BITS-1:0] r_m_len;

  assign w_len       = s_req_len;
  assign w_drain     = r_m_valid & m_req_ready;
  assign w_can_grant = !r_m_valid | m_req_ready;
  assign w_req       = w_elig & {N_CHAN{w_can_grant}};

  dtu_rr_arb #(.N_CHAN(N_CHAN), .PTR_W(c_PTR_W)) u_arb (
    .req       (w_req),
    .ptr       (r_rr_ptr),
    .grant     (w_gnt_oh),
    .grant_idx (w_gnt_idx),
    .grant_any (w_gnt_any)
  );

  assign s_req_ready = w_gnt_oh;
  assign w_gnt_legal = w_gnt_any & !w_illegal[w_gnt_idx];
  assign w_gnt_ill   = w_gnt_any &  w_illegal[w_gnt_idx];

  assign w_tid_ok      = (32'(s_axis_tid) < N_CHAN);
  assign w_tid_idx     = s_axis_tid[c_PTR_W-1:0];
  assign s_axis_tready = w_tid_ok ? m_axis_tready[w_tid_idx] : 1'b1;
  assign w_data_err    = s_axis_tvalid & !w_tid_ok;

  for (genvar c = 0; c < N_CHAN; c++) begin : g_chan
    logic [c_BW-1:0] w_take;
    logic [c_BW-1:0] w_sum;

    // Illegal requests stay eligible so they are accepted and dropped, never stuck.
    assign w_beats[c]   = ({1'b0, w_len[c]} + c_BW'(c_BEAT_BYTES - 1)) >> c_BEAT_SHIFT;
    assign w_illegal[c] = (w_len[c] == '0) || (w_beats[c] > c_CRED_MAX_B);
    assign w_short[c]   = s_req_valid[c] && !w_illegal[c] && (w_beats[c] > c_BW'(r_credit[c]));
    assign w_elig[c]    = s_req_valid[c] && !w_short[c];

    assign m_axis_tdata[c*DATA_BITS +: DATA_BITS]     = s_axis_tdata;
    assign m_axis_tkeep[c*DATA_BITS/8 +: DATA_BITS/8] = s_axis_tkeep;
    assign m_axis_tlast[c]  = s_axis_tlast;
    assign m_axis_tvalid[c] = s_axis_tvalid && w_tid_ok && (w_tid_idx == c_PTR_W'(c));
    assign w_refund[c]      = m_axis_tvalid[c] && m_axis_tready[c];

    // A granted request always holds beats <= credit, so the sum cannot underflow.
    assign w_take = (w_gnt_legal && (w_gnt_idx == c_PTR_W'(c))) ? w_beats[c] : '0;
    assign w_sum  = c_BW'(r_credit[c]) - w_take + c_BW'(w_refund[c]);
    assign w_sat[c]      = (w_sum > c_CRED_MAX_B);
    assign w_cred_nxt[c] = w_sat[c] ? c_CRED_MAX : w_sum[c_CRED_W-1:0];
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_credit  <= {N_CHAN{c_CRED_MAX}};
      r_rr_ptr  <= '0;
      r_m_valid <= 1'b0;
      r_m_len   <= '0;
      r_m_chan  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_credit <= w_cred_nxt;
      if (w_gnt_any)
        r_rr_ptr <= (w_gnt_idx == c_PTR_W'(N_CHAN - 1)) ? '0 : w_gnt_idx + 1'b1;
      if (w_gnt_legal) begin
        r_m_valid <= 1'b1;
        r_m_len   <= w_len[w_gnt_idx];
        r_m_chan  <= w_gnt_idx;
      end else if (w_drain) begin
        r_m_valid <= 1'b0;
      end
      r_err <= w_gnt_ill | w_data_err | (|w_sat);
    end
  end

  assign m_req_valid = r_m_valid;
  assign m_req_len   = r_m_len;
  assign m_req_chan  = r_m_chan;
  assign err_pulse   = r_err;

`ifdef DTU_CRED_STATS_EN
  logic [N_CHAN-1:0][31:0] r_stat_grants;
  logic [N_CHAN-1:0][31:0] r_stat_stalls;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_stat_grants <= '0;
      r_stat_stalls <= '0;
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (w_gnt_oh[c]) r_stat_grants[c] <= r_stat_grants[c] + 32'd1;
        if (w_short[c])  r_stat_stalls[c] <= r_stat_stalls[c] + 32'd1;
      end
    end
  end

  assign stat_grants = r_stat_grants;
  assign stat_stalls = r_stat_stalls;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dtu_rd_credit_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dtu_rd_credit_arb                                                       |
// | Directed scoreboard bench for the credit-gated read arbiter.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dtu_rd_credit_arb;

  localparam int N  = 4;
  localparam int DB = 512;
  localparam int LB = 28;
  localparam int PB = 4;

  logic              aclk = 1'b0;
  logic              areset;
  logic [N-1:0]      s_req_valid;
  logic [N-1:0]      s_req_ready;
  logic [N*LB-1:0]   s_req_len;
  logic              m_req_valid;
  logic              m_req_ready;
  logic [LB-1:0]     m_req_len;
  logic [1:0]        m_req_chan;
  logic [DB-1:0]     s_axis_tdata;
  logic [DB/8-1:0]   s_axis_tkeep;
  logic              s_axis_tlast;
  logic              s_axis_tvalid;
  logic [PB-1:0]     s_axis_tid;
  logic              s_axis_tready;
  logic [N*DB-1:0]   m_axis_tdata;
  logic [N*DB/8-1:0] m_axis_tkeep;
  logic [N-1:0]      m_axis_tlast;
  logic [N-1:0]      m_axis_tvalid;
  logic [N-1:0]      m_axis_tready;
  logic              err_pulse;
`ifdef DTU_CRED_STATS_EN
  logic [N*32-1:0]   stat_grants;
  logic [N*32-1:0]   stat_stalls;
`endif

  dtu_rd_credit_arb #(.N_CHAN(N), .DATA_BITS(DB), .LEN_BITS(LB), .CRED_BEATS(64), .PID_BITS(PB)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_req_valid   (s_req_valid),
    .s_req_ready   (s_req_ready),
    .s_req_len     (s_req_len),
    .m_req_valid   (m_req_valid),
    .m_req_ready   (m_req_ready),
    .m_req_len     (m_req_len),
    .m_req_chan    (m_req_chan),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tid    (s_axis_tid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .err_pulse     (err_pulse)
`ifdef DTU_CRED_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_stalls   (stat_stalls)
`endif
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [LB-1:0] len;
    logic [1:0]    chan;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input int len);
    exp_t e;
    e.len  = LB'(len);
    e.chan = 2'(c);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    @(negedge aclk);
  endtask

  task automatic req(input int c, input int len);
    s_req_valid[c]         = 1'b1;
    s_req_len[c*LB +: LB]  = LB'(len);
  endtask

  task automatic idle_all();
    s_req_valid   = '0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = '0;
  endtask

  task automatic beat(input int tid, input logic [N-1:0] rdy);
    s_axis_tvalid = 1'b1;
    s_axis_tid    = PB'(tid);
    s_axis_tdata  = {16{$urandom()}};
    m_axis_tready = rdy;
  endtask

  task automatic do_reset();
    step();
    areset = 1'b1;
    idle_all();
    m_req_ready = 1'b1;
    step();
    areset = 1'b0;
  endtask

  // Scoreboard: every forwarded request must match the oldest expected grant.
  always @(negedge aclk) begin
    exp_t e;
    if (!areset && m_req_valid && m_req_ready) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_unexpected: forwarded chan=%0d len=%0d, expected none", m_req_chan, m_req_len);
      end else begin
        e = sb.pop_front();
        chk("fwd_chan", 64'(m_req_chan), 64'(e.chan));
        chk("fwd_len", 64'(m_req_len), 64'(e.len));
      end
    end
  end

  initial begin
    areset        = 1'b1;
    s_req_valid   = '0;
    s_req_len     = '0;
    m_req_ready   = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tid    = '0;
    m_axis_tready = '0;
    step();
    step();
    areset = 1'b0;
    settle();
    chk("rst_mvalid", 64'(m_req_valid), 64'd0);
    chk("rst_sready", 64'(s_req_ready), 64'd0);
    chk("rst_err", 64'(err_pulse), 64'd0);
    chk("rst_credits", 64'(dut.r_credit), 64'({4{7'd64}}));

    // 1: full-credit request drains ch0; the next one waits for a refund.
    step(); req(0, 4096); settle();
    chk("t1_grant", 64'(s_req_ready), 64'b0001); push(0, 4096);
    step(); req(0, 64); settle();
    chk("t1_blocked", 64'(s_req_ready), 64'd0);
    chk("t1_cred0", 64'(dut.r_credit[0]), 64'd0);
    step(); settle();
    chk("t1_still_blocked", 64'(s_req_ready), 64'd0);
    step(); beat(0, 4'b0001); settle();
    chk("t1_demux", 64'(m_axis_tvalid), 64'b0001);
    chk("t1_tready", 64'(s_axis_tready), 64'd1);
    chk("t1_tdata", m_axis_tdata[2*DB +: 64], s_axis_tdata[63:0]);
    chk("t1_no_grant_same_cycle", 64'(s_req_ready), 64'd0);
    step(); s_axis_tvalid = 1'b0; settle();
    chk("t1_grant_after_refund", 64'(s_req_ready), 64'b0001); push(0, 64);
    step(); idle_all(); settle();
    chk("t1_cred0_end", 64'(dut.r_credit[0]), 64'd0);
    do_reset();

    // 2: all channels valid, back-to-back round robin.
    step();
    for (int i = 0; i < N; i++) req(i, 64);
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] oh;
      oh = N'(1 << (k % N));
      settle();
      chk("t2_rr", 64'(s_req_ready), 64'(oh));
      push(k % N, 64);
      step();
    end
    idle_all(); settle();
    step(); settle();
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    do_reset();

    // Slot held under backpressure, then drain and refill in one cycle.
    step(); req(1, 128); settle();
    chk("th_grant", 64'(s_req_ready), 64'b0010); push(1, 128);
    step(); idle_all(); req(2, 64); m_req_ready = 1'b0; settle();
    chk("th_full", 64'(s_req_ready), 64'd0);
    step(); settle();
    chk("th_len_held", 64'(m_req_len), 64'd128);
    chk("th_chan_held", 64'(m_req_chan), 64'd1);
    step(); m_req_ready = 1'b1; settle();
    chk("th_refill", 64'(s_req_ready), 64'b0100); push(2, 64);
    step(); idle_all(); settle();
    do_reset();

    // 3: starved ch1 is skipped in favour of ch2; pointer lands on ch3.
    step(); req(1, 4096); settle();
    chk("t3_g1", 64'(s_req_ready), 64'b0010); push(1, 4096);
    step(); idle_all(); req(0, 64); settle();
    chk("t3_g0", 64'(s_req_ready), 64'b0001); push(0, 64);
    step(); idle_all(); req(1, 64); req(2, 64); settle();
    chk("t3_skip", 64'(s_req_ready), 64'b0100); push(2, 64);
    step(); idle_all(); req(0, 64); req(2, 64); req(3, 64); settle();
    chk("t3_ptr", 64'(s_req_ready), 64'b1000); push(3, 64);
    step(); idle_all(); settle();
    do_reset();

    // 4: same-cycle grant and refund on ch0 at credit 1.
    step(); req(0, 4032); settle();
    chk("t4_grant63", 64'(s_req_ready), 64'b0001); push(0, 4032);
    step(); idle_all(); settle();
    chk("t4_cred1", 64'(dut.r_credit[0]), 64'd1);
    step(); req(0, 64); beat(0, 4'b0001); settle();
    chk("t4_grant1", 64'(s_req_ready), 64'b0001); push(0, 64);
    step(); idle_all(); settle();
    chk("t4_cred_kept", 64'(dut.r_credit[0]), 64'd1);
    do_reset();

    // 5: protocol errors.
    step(); req(3, 0); settle();
    chk("t5_len0_accept", 64'(s_req_ready), 64'b1000);
    step(); idle_all(); settle();
    chk("t5_len0_err", 64'(err_pulse), 64'd1);
    chk("t5_len0_nofwd", 64'(m_req_valid), 64'd0);
    step(); settle();
    chk("t5_err_pulse_len", 64'(err_pulse), 64'd0);
    step(); req(1, 4097); settle();
    chk("t5_big_accept", 64'(s_req_ready), 64'b0010);
    step(); idle_all(); settle();
    chk("t5_big_err", 64'(err_pulse), 64'd1);
    chk("t5_big_nofwd", 64'(m_req_valid), 64'd0);
    chk("t5_big_cred", 64'(dut.r_credit[1]), 64'd64);
    step(); beat(7, 4'b0000); settle();
    chk("t5_tid_tready", 64'(s_axis_tready), 64'd1);
    chk("t5_tid_drop", 64'(m_axis_tvalid), 64'd0);
    step(); idle_all(); settle();
    chk("t5_tid_err", 64'(err_pulse), 64'd1);
    step(); beat(2, 4'b0100); settle();
    chk("t5_ref_demux", 64'(m_axis_tvalid), 64'b0100);
    step(); idle_all(); settle();
    chk("t5_sat_err", 64'(err_pulse), 64'd1);
    chk("t5_sat_cred", 64'(dut.r_credit[2]), 64'd64);
    step(); settle();
    chk("t5_quiet", 64'(err_pulse), 64'd0);

    // 6: asynchronous reset with a held request and depleted credit.
    step(); m_req_ready = 1'b0; req(0, 4096); settle();
    chk("t6_grant", 64'(s_req_ready), 64'b0001);
    step(); idle_all(); settle();
    chk("t6_mvalid", 64'(m_req_valid), 64'd1);
    chk("t6_depleted", 64'(dut.r_credit[0]), 64'd0);
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("t6_async_mvalid", 64'(m_req_valid), 64'd0);
    chk("t6_async_credits", 64'(dut.r_credit), 64'({4{7'd64}}));
`ifdef DTU_CRED_STATS_EN
    chk("t6_stat_grants", 64'(stat_grants == '0), 64'd1);
    chk("t6_stat_stalls", 64'(stat_stalls == '0), 64'd1);
`endif
    step();
    areset = 1'b0;
    m_req_ready = 1'b1;
    step(); settle();
    chk("end_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
